uart_tx_piso: RTL and testbench
===============================

Name: uart_tx_piso

Overview:
- Parallel-in/serial-out transmitter: accepts a DATA_W-bit word over a valid/ready handshake and shifts it out on a single line as a frame: start bit, data LSB-first, stop bit.
- Transmit-side counterpart to the team's flip-flop/shift-register capture logic. A serial receiver built from the same sequential primitives samples this line.
- Sits between a byte-producing client and the off-block serial pin.

Parameters:
- DATA_W, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, synchronous, active-low; sampled only on posedge clk.
- tx_data  input  DATA_W  word to send; sampled only on handshake.
- tx_valid  input  1  client has a word.
- tx_ready  output  1  block can accept a word (state IDLE).
- tx_serial  output  1  serial line; idle level 1.
- busy  output  1  frame in progress (START/DATA/STOP).
- done  output  1  one-cycle pulse, frame complete.

Behaviour:
- Reset: at posedge clk with rstn=0, all of the following take effect regardless of state, including mid-frame:
  - state=IDLE, tx_serial=1, tx_ready=1, busy=0, done=0.
  - Shift register and counters cleared.
  - A frame in flight is abandoned. No stop bit is emitted; the line returns to 1 at that edge.
- All outputs are registered (no combinational path from inputs).
- FSM states: IDLE, START, DATA, STOP.
- Handshake: a transfer occurs at a posedge where tx_valid=1 and tx_ready=1 (edge k).
  - Latches tx_data into the shift register.
  - Moves the FSM to START.
  - Drives tx_ready=0 and busy=1 from cycle k+1.
- tx_valid without tx_ready: no effect. tx_data changes while busy: ignored.
- Frame timing, C=CLKS_PER_BIT:
  - START: tx_serial=0 for cycles k+1 .. k+C.
  - DATA: bit i (i=0..DATA_W-1) driven for cycles k+1+(i+1)*C .. k+(i+2)*C, LSB first. The shift register shifts right once per bit period.
  - STOP: tx_serial=1 for C cycles.
  - Total frame length is (DATA_W+2)*C cycles.
- Completion, at cycle k+1+(DATA_W+2)*C:
  - state=IDLE, tx_ready=1, busy=0.
  - done=1 for exactly that cycle.
  - tx_serial stays 1.
- Back-to-back: if tx_valid is held high, the next handshake occurs at the edge ending the done cycle. The next start bit begins one cycle later, giving exactly one idle-high cycle between frames.
- Bit timer:
  - Counts 0..C-1. Its wrap marks a bit boundary.
  - Width is max(1, $clog2(C)).
  - C=1 is legal: one cycle per bit, timer always wrapping.
- Bit counter:
  - Counts 0..DATA_W-1 in DATA. The transition to STOP happens at the wrap of bit DATA_W-1.
  - Width is max(1, $clog2(DATA_W)).
  - No overflow beyond DATA_W-1.
- Invariants:
  - tx_ready == !busy at all times.
  - done is never asserted while busy=1.
  - Any X on tx_data outside a handshake must not propagate to tx_serial.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, STOP}.
  - Constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
- One natural sub-module: bit_timer.
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rstn, run.
  - Output tick, a one-cycle pulse at count C-1.
  - Sync active-low reset; count clears whenever run=0.
- The FSM and shift register remain in uart_tx_piso.

Test Plan:
1. Reset then idle: hold rstn=0 for 3 cycles, release, tx_valid=0 for 20 cycles -> tx_serial=1, tx_ready=1, busy=0, done=0 throughout.
2. Single frame with DATA_W=8, C=4, tx_data=8'hA5 pulsed valid at edge k:
   - Line sequence in 4-cycle groups is 0,1,0,1,0,0,1,0,1,1.
   - done pulses at k+41; tx_ready returns at k+41.
3. Back-to-back: tx_valid held 1 with 8'h00 then 8'hFF -> two 40-cycle frames separated by exactly one idle-high cycle; exactly two done pulses.
4. Data hold: change tx_data every cycle during a frame of 8'h3C -> the line carries 0x3C bits (0,0,1,1,1,1,0,0 LSB-first); later values are ignored.
5. Mid-frame reset: rstn=0 for one edge during DATA bit 3 -> next cycle tx_serial=1, tx_ready=1, no done pulse; a new frame 8'h5A then sends correctly.
6. C=1, DATA_W=8, tx_data=8'h81 -> 10-cycle frame 0,1,0,0,0,0,0,0,1,1; done at k+11.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line levels for the PISO UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_piso_if.sv
// Client-side valid/ready word handshake into the UART transmitter.
interface uart_tx_piso_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_piso_bit_timer.sv
// Bit-period timer: tick pulses on the last clock of each serial bit while run is high.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = run && w_wrap;

  // Holding the count at zero while idle aligns the first tick to the frame start.
  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_piso.sv
// Parallel-in/serial-out UART transmitter: start bit, DATA_W bits LSB-first, stop bit.
module uart_tx_piso
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rstn,
  uart_tx_piso_if.slave   bus,
  output logic            tx_serial,
  output logic            busy,
  output logic            done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shift_dn;
  logic [BIT_W-1:0]  r_bitcnt, w_bitcnt_nxt;
  logic              r_serial, w_serial_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy, r_ready;
  logic              w_run, w_tick, w_accept;

  assign w_run      = (r_state != IDLE);
  assign w_accept   = bus.tx_valid && r_ready;
  assign w_shift_dn = r_shift >> 1;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .run  (w_run),
    .tick (w_tick)
  );

  // Next-state logic computes the line level one cycle ahead so the pin is a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_serial_nxt = r_serial;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_serial_nxt = LINE_IDLE;
        if (w_accept) begin
          w_state_nxt  = START;
          w_shift_nxt  = bus.tx_data;
          w_serial_nxt = START_LVL;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt  = DATA;
          w_bitcnt_nxt = '0;
          w_serial_nxt = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = w_shift_dn;
          if (r_bitcnt == LAST_BIT) begin
            w_state_nxt  = STOP;
            w_serial_nxt = STOP_LVL;
          end else begin
            w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
            w_serial_nxt = w_shift_dn[0];
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt  = IDLE;
          w_done_nxt   = 1'b1;
          w_serial_nxt = LINE_IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_serial <= LINE_IDLE;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_serial <= w_serial_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_ready  <= (w_state_nxt == IDLE);
    end
  end

  assign tx_serial    = r_serial;
  assign busy         = r_busy;
  assign done         = r_done;
  assign bus.tx_ready = r_ready;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Self-checking bench for uart_tx_piso at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_uart_tx_piso;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn4, rstn1;
  logic ser4, busy4, done4;
  logic ser1, busy1, done1;

  uart_tx_piso_if #(.DATA_W(DW)) bus4 ();
  uart_tx_piso_if #(.DATA_W(DW)) bus1 ();

  uart_tx_piso #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rstn(rstn4), .bus(bus4.slave),
    .tx_serial(ser4), .busy(busy4), .done(done4)
  );

  uart_tx_piso #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rstn(rstn1), .bus(bus1.slave),
    .tx_serial(ser1), .busy(busy1), .done(done1)
  );

  // Status nibble: {serial, busy, ready, done}
  wire [3:0] st4 = {ser4, busy4, bus4.tx_ready, done4};
  wire [3:0] st1 = {ser1, busy1, bus1.tx_ready, done1};

  localparam logic [3:0] ST_IDLE = 4'b1010;
  localparam logic [3:0] ST_DONE = 4'b1011;

  int n_chk  = 0;
  int n_fail = 0;
  int done_tot = 0;

  always @(negedge clk) if (done4 === 1'b1) done_tot++;

  // Reference: frame is start(0), data LSB-first, stop(1), each held c cycles.
  function automatic logic exp_line(input logic [DW-1:0] d, input int c, input int t);
    int b;
    b = t / c;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_frame(input logic [DW-1:0] d, input int c, input int t);
    return {exp_line(d, c, t), 3'b100};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn4 = 1'b0; rstn1 = 1'b0;
    bus4.tx_valid = 1'b0; bus4.tx_data = '0;
    bus1.tx_valid = 1'b0; bus1.tx_data = '0;
    repeat (3) begin
      step();
      n_chk++;
      if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL reset4: got %b expected %b", st4, ST_IDLE); end
      n_chk++;
      if (st1 !== ST_IDLE) begin n_fail++; $display("FAIL reset1: got %b expected %b", st1, ST_IDLE); end
    end
    rstn4 = 1'b1; rstn1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++;
      if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL idle4 c=%0d: got %b expected %b", i, st4, ST_IDLE); end
      n_chk++;
      if (st1 !== ST_IDLE) begin n_fail++; $display("FAIL idle1 c=%0d: got %b expected %b", i, st1, ST_IDLE); end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d = 8'hA5;
    bus4.tx_data = d; bus4.tx_valid = 1'b1;
    step();
    bus4.tx_valid = 1'b0; bus4.tx_data = DW'($urandom);
    for (int t = 0; t < (DW + 2) * 4; t++) begin
      n_chk++;
      if (st4 !== exp_frame(d, 4, t)) begin
        n_fail++; $display("FAIL single_A5 t=%0d: got %b expected %b", t, st4, exp_frame(d, 4, t));
      end
      step();
    end
    n_chk++;
    if (st4 !== ST_DONE) begin n_fail++; $display("FAIL single_done: got %b expected %b", st4, ST_DONE); end
    step();
    n_chk++;
    if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL single_after: got %b expected %b", st4, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] da = 8'h00;
    logic [DW-1:0] db = 8'hFF;
    int d0 = done_tot;
    bus4.tx_data = da; bus4.tx_valid = 1'b1;
    step();
    bus4.tx_data = db;
    for (int t = 0; t < (DW + 2) * 4; t++) begin
      n_chk++;
      if (st4 !== exp_frame(da, 4, t)) begin
        n_fail++; $display("FAIL b2b_first t=%0d: got %b expected %b", t, st4, exp_frame(da, 4, t));
      end
      step();
    end
    n_chk++;
    if (st4 !== ST_DONE) begin n_fail++; $display("FAIL b2b_gap: got %b expected %b", st4, ST_DONE); end
    step();
    bus4.tx_valid = 1'b0;
    for (int t = 0; t < (DW + 2) * 4; t++) begin
      n_chk++;
      if (st4 !== exp_frame(db, 4, t)) begin
        n_fail++; $display("FAIL b2b_second t=%0d: got %b expected %b", t, st4, exp_frame(db, 4, t));
      end
      step();
    end
    n_chk++;
    if (st4 !== ST_DONE) begin n_fail++; $display("FAIL b2b_done2: got %b expected %b", st4, ST_DONE); end
    repeat (3) step();
    n_chk++;
    if (done_tot - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_tot - d0); end
  endtask

  task automatic test_data_hold();
    logic [DW-1:0] d = 8'h3C;
    bus4.tx_data = d; bus4.tx_valid = 1'b1;
    step();
    bus4.tx_valid = 1'b0;
    for (int t = 0; t < (DW + 2) * 4; t++) begin
      n_chk++;
      if (st4 !== exp_frame(d, 4, t)) begin
        n_fail++; $display("FAIL hold_3C t=%0d: got %b expected %b", t, st4, exp_frame(d, 4, t));
      end
      bus4.tx_data = (t % 2 == 0) ? 'x : DW'($urandom);
      step();
    end
    n_chk++;
    if (st4 !== ST_DONE) begin n_fail++; $display("FAIL hold_done: got %b expected %b", st4, ST_DONE); end
    bus4.tx_data = '0;
    step();
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d = DW'($urandom);
    logic [DW-1:0] d2 = 8'h5A;
    int d0;
    bus4.tx_data = d; bus4.tx_valid = 1'b1;
    step();
    bus4.tx_valid = 1'b0;
    // Cycle offsets 16..19 carry data bit 3 at four clocks per bit.
    for (int t = 0; t < 18; t++) begin
      n_chk++;
      if (st4 !== exp_frame(d, 4, t)) begin
        n_fail++; $display("FAIL midrst_pre t=%0d: got %b expected %b", t, st4, exp_frame(d, 4, t));
      end
      if (t < 17) step();
    end
    d0 = done_tot;
    rstn4 = 1'b0;
    step();
    rstn4 = 1'b1;
    n_chk++;
    if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL midrst_abort: got %b expected %b", st4, ST_IDLE); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL midrst_idle c=%0d: got %b expected %b", i, st4, ST_IDLE); end
    end
    n_chk++;
    if (done_tot !== d0) begin n_fail++; $display("FAIL midrst_nodone: got %0d expected %0d", done_tot, d0); end
    bus4.tx_data = d2; bus4.tx_valid = 1'b1;
    step();
    bus4.tx_valid = 1'b0;
    for (int t = 0; t < (DW + 2) * 4; t++) begin
      n_chk++;
      if (st4 !== exp_frame(d2, 4, t)) begin
        n_fail++; $display("FAIL midrst_5A t=%0d: got %b expected %b", t, st4, exp_frame(d2, 4, t));
      end
      step();
    end
    n_chk++;
    if (st4 !== ST_DONE) begin n_fail++; $display("FAIL midrst_done: got %b expected %b", st4, ST_DONE); end
    step();
  endtask

  task automatic test_c1();
    logic [DW-1:0] d = 8'h81;
    bus1.tx_data = d; bus1.tx_valid = 1'b1;
    step();
    bus1.tx_valid = 1'b0; bus1.tx_data = DW'($urandom);
    for (int t = 0; t < DW + 2; t++) begin
      n_chk++;
      if (st1 !== exp_frame(d, 1, t)) begin
        n_fail++; $display("FAIL c1_81 t=%0d: got %b expected %b", t, st1, exp_frame(d, 1, t));
      end
      step();
    end
    n_chk++;
    if (st1 !== ST_DONE) begin n_fail++; $display("FAIL c1_done: got %b expected %b", st1, ST_DONE); end
    step();
    n_chk++;
    if (st1 !== ST_IDLE) begin n_fail++; $display("FAIL c1_after: got %b expected %b", st1, ST_IDLE); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int gap;
    for (int f = 0; f < 8; f++) begin
      d = DW'($urandom);
      gap = $urandom_range(0, 3);
      bus4.tx_data = d; bus4.tx_valid = 1'b1;
      step();
      bus4.tx_valid = 1'b0; bus4.tx_data = DW'($urandom);
      for (int t = 0; t < (DW + 2) * 4; t++) begin
        n_chk++;
        if (st4 !== exp_frame(d, 4, t)) begin
          n_fail++; $display("FAIL rand f=%0d d=%h t=%0d: got %b expected %b", f, d, t, st4, exp_frame(d, 4, t));
        end
        step();
      end
      n_chk++;
      if (st4 !== ST_DONE) begin n_fail++; $display("FAIL rand_done f=%0d: got %b expected %b", f, st4, ST_DONE); end
      for (int g = 0; g < gap; g++) begin
        step();
        n_chk++;
        if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL rand_gap f=%0d: got %b expected %b", f, st4, ST_IDLE); end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_data_hold();
    test_mid_reset();
    test_c1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
